// File: rtl/key_sw_dev_if.sv
// key_sw_dev_if
//   Processor data-memory bus to the key/switch peripheral.
//   Parameter DBITS : data and address bus width (16).
//   Signals:
//     abus  address from the processor M stage
//     din   store data
//     we    store strobe
//     re    load strobe, used only for read side effects
//     dout  read data, combinational from abus
//     sel   high when abus hits one of the peripheral addresses
//   Modports: master (processor side), slave (peripheral side).
interface key_sw_dev_if #(
  parameter int DBITS = 16
);
  logic [DBITS-1:0] abus;
  logic [DBITS-1:0] din;
  logic             we;
  logic             re;
  logic [DBITS-1:0] dout;
  logic             sel;

  modport master (
    output abus, din, we, re,
    input  dout, sel
  );

  modport slave (
    input  abus, din, we, re,
    output dout, sel
  );
endinterface

// File: rtl/key_sw_dev.sv
// key_sw_dev
//   Memory-mapped push-button / slide-switch peripheral with debouncing.
//   Register map:
//     FFF0 KDATA (RO) {12'b0, keys}
//     FFF2 SDATA (RO) {6'b0, switches}
//     FFF4 KCTRL      bit0 READY, bit2 OVERRUN, bit8 IE
//     FFF6 SCTRL      bit0 READY, bit2 OVERRUN, bit8 IE
//   Any other address: sel = 0, dout = 16'hDEAD.
//   Parameters:
//     DBITS  : bus width (16)
//     DEBCYC : cycles an input must be stable before it commits (2..65535)
//   Ports:
//     clk    sole clock, rising edge
//     reset  synchronous, active-high reset
//     bus    key_sw_dev_if slave modport (abus, din, we, re, dout, sel)
//     key    raw push-buttons, asynchronous, active-low
//     sw     raw slide switches, asynchronous
//     intr   registered interrupt request
//   Configuration macro KSW_INTR_EN:
//     defined   -> IE bits are writable and intr is driven from READY & IE
//     undefined -> IE reads 0, writes to IE are ignored, intr is constant 0
module key_sw_dev #(
  parameter int DBITS  = 16,
  parameter int DEBCYC = 50000
) (
  input  logic          clk,
  input  logic          reset,
  key_sw_dev_if.slave   bus,
  input  logic [3:0]    key,
  input  logic [9:0]    sw,
  output logic          intr
);

  // Group 0 = keys (low 4 bits of a 10-bit lane), group 1 = switches.
  localparam int          NGRP    = 2;
  localparam logic [15:0] CNT_MAX = 16'(DEBCYC - 1);

  logic [15:0]     addr;
  logic [9:0]      raw_in [NGRP];
  logic [9:0]      comm_q [NGRP];
  logic [NGRP-1:0] ready_q;
  logic [NGRP-1:0] ovr_q;
  logic [NGRP-1:0] ie_q;

  assign addr      = 16'(bus.abus);
  assign raw_in[0] = {6'b0, key};
  assign raw_in[1] = sw;

  genvar gi;
  generate
    for (gi = 0; gi < NGRP; gi++) begin : g_grp
      localparam logic [9:0]  RST_VAL   = (gi == 0) ? 10'h00F : 10'h000;
      localparam logic [15:0] DATA_ADDR = 16'hFFF0 + 16'(2 * gi);
      localparam logic [15:0] CTRL_ADDR = 16'hFFF4 + 16'(2 * gi);

      logic [9:0]  sync1_reg;
      logic [9:0]  sync2_reg;
      logic [9:0]  cand_reg;
      logic [9:0]  comm_reg;
      logic [15:0] cnt_reg;
      logic        ready_reg;
      logic        ready_next;
      logic        ovr_reg;
      logic        ovr_next;
      logic        commit;
      logic        rd_clr;
      logic        wr_ctl;
      logic        ready_clr;

      // One counter and one candidate per group: any bit change in the
      // synchronized value restarts the stability window for the whole group.
      always_ff @(posedge clk) begin
        if (reset) begin
          sync1_reg <= RST_VAL;
          sync2_reg <= RST_VAL;
          cand_reg  <= RST_VAL;
          comm_reg  <= RST_VAL;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= raw_in[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg != cand_reg) begin
            cand_reg <= sync2_reg;
            cnt_reg  <= '0;
          end else if (cand_reg != comm_reg) begin
            // Counter stops at its maximum; it is only cleared by a new candidate.
            if (cnt_reg == CNT_MAX) begin
              comm_reg <= cand_reg;
            end else begin
              cnt_reg <= cnt_reg + 16'd1;
            end
          end
        end
      end

      assign commit = (sync2_reg == cand_reg) && (cand_reg != comm_reg) &&
                      (cnt_reg == CNT_MAX);
      assign rd_clr    = bus.re && (addr == DATA_ADDR);
      assign wr_ctl    = bus.we && (addr == CTRL_ADDR);
      assign ready_clr = rd_clr || (wr_ctl && !bus.din[0]);

      // A new event always wins over a clear. OVERRUN only flags an event
      // that lands on an unacknowledged one, so a same-cycle clear of READY
      // counts as the acknowledgement.
      always_comb begin
        ready_next = ready_reg;
        ovr_next   = ovr_reg;
        if (wr_ctl && !bus.din[2]) begin
          ovr_next = 1'b0;
        end
        if (commit && ready_reg && !ready_clr) begin
          ovr_next = 1'b1;
        end
        if (ready_clr) begin
          ready_next = 1'b0;
        end
        if (commit) begin
          ready_next = 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          ready_reg <= 1'b0;
          ovr_reg   <= 1'b0;
        end else begin
          ready_reg <= ready_next;
          ovr_reg   <= ovr_next;
        end
      end

`ifdef KSW_INTR_EN
      logic ie_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          ie_reg <= 1'b0;
        end else if (wr_ctl) begin
          ie_reg <= bus.din[8];
        end
      end

      assign ie_q[gi] = ie_reg;
`else
      assign ie_q[gi] = 1'b0;
`endif

      assign comm_q[gi]  = comm_reg;
      assign ready_q[gi] = ready_reg;
      assign ovr_q[gi]   = ovr_reg;
    end
  endgenerate

  // Read mux
  logic [15:0] rd_data;
  logic        sel_int;

  always_comb begin
    rd_data = 16'hDEAD;
    sel_int = 1'b0;
    case (addr)
      16'hFFF0: begin
        rd_data = {12'b0, comm_q[0][3:0]};
        sel_int = 1'b1;
      end
      16'hFFF2: begin
        rd_data = {6'b0, comm_q[1]};
        sel_int = 1'b1;
      end
      16'hFFF4: begin
        rd_data = {7'b0, ie_q[0], 5'b0, ovr_q[0], 1'b0, ready_q[0]};
        sel_int = 1'b1;
      end
      16'hFFF6: begin
        rd_data = {7'b0, ie_q[1], 5'b0, ovr_q[1], 1'b0, ready_q[1]};
        sel_int = 1'b1;
      end
      default: begin
        rd_data = 16'hDEAD;
        sel_int = 1'b0;
      end
    endcase
  end

  assign bus.dout = DBITS'(rd_data);
  assign bus.sel  = sel_int;

`ifdef KSW_INTR_EN
  logic intr_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      intr_reg <= 1'b0;
    end else begin
      intr_reg <= |(ready_q & ie_q);
    end
  end

  assign intr = intr_reg;

  logic unused_bits;
  assign unused_bits = ^{bus.din[15:9], bus.din[7:3], bus.din[1], comm_q[0][9:4]};
`else
  assign intr = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{bus.din[15:3], bus.din[1], comm_q[0][9:4]};
`endif

endmodule

// File: tb/tb_key_sw_dev.sv
// tb_key_sw_dev
//   Directed bench for key_sw_dev with DEBCYC = 4. A behavioural model
//   (delay-by-two input stream, run-length stability rule, register rules)
//   is compared against dout/sel/intr on every falling edge; directed steps
//   add hand-computed literal expectations.
module tb_key_sw_dev;

  localparam int DEBCYC = 4;
`ifdef KSW_INTR_EN
  localparam bit INTR_EN = 1'b1;
`else
  localparam bit INTR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] key = 4'hF;
  logic [9:0] sw = 10'h000;
  logic       intr;

  key_sw_dev_if #(.DBITS(16)) bus ();

  key_sw_dev #(.DBITS(16), .DEBCYC(DEBCYC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .key   (key),
    .sw    (sw),
    .intr  (intr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void check(string nm, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  logic [9:0] m_comm    [2];
  logic [9:0] m_d1      [2];
  logic [9:0] m_d2      [2];
  logic [9:0] m_run_val [2];
  int         m_run_len [2];
  bit         m_ready   [2];
  bit         m_ovr     [2];
  bit         m_ie      [2];
  bit         m_intr;
  bit         started = 1'b0;

  function automatic logic [9:0] rst_val(int g);
    return (g == 0) ? 10'h00F : 10'h000;
  endfunction

  always @(posedge clk) begin : model
    logic [9:0] raw;
    logic [9:0] syn;
    bit         commit, rclr, wctl, rdy_clr, oset;
    if (reset) begin
      for (int g = 0; g < 2; g++) begin
        m_comm[g]    = rst_val(g);
        m_d1[g]      = rst_val(g);
        m_d2[g]      = rst_val(g);
        m_run_val[g] = rst_val(g);
        m_run_len[g] = 0;
        m_ready[g]   = 1'b0;
        m_ovr[g]     = 1'b0;
        m_ie[g]      = 1'b0;
      end
      m_intr  = 1'b0;
      started = 1'b1;
    end else begin
      m_intr = (m_ready[0] && m_ie[0]) || (m_ready[1] && m_ie[1]);
      for (int g = 0; g < 2; g++) begin
        raw = (g == 0) ? {6'b0, key} : sw;
        // input is seen two edges after it is sampled
        syn     = m_d2[g];
        m_d2[g] = m_d1[g];
        m_d1[g] = raw;
        if (syn == m_run_val[g]) begin
          if (m_run_len[g] < 1000) m_run_len[g]++;
        end else begin
          m_run_val[g] = syn;
          m_run_len[g] = 1;
        end
        // a value seen DEBCYC+1 times in a row (one to capture it, DEBCYC to count) commits
        commit  = (m_run_len[g] == DEBCYC + 1) && (m_run_val[g] != m_comm[g]);
        rclr    = bus.re && (bus.abus == 16'hFFF0 + 16'(2 * g));
        wctl    = bus.we && (bus.abus == 16'hFFF4 + 16'(2 * g));
        rdy_clr = rclr || (wctl && !bus.din[0]);
        oset    = commit && m_ready[g] && !rdy_clr;
        if (oset) m_ovr[g] = 1'b1;
        else if (wctl && !bus.din[2]) m_ovr[g] = 1'b0;
        if (commit) m_ready[g] = 1'b1;
        else if (rdy_clr) m_ready[g] = 1'b0;
        if (wctl && INTR_EN) m_ie[g] = bus.din[8];
        if (commit) m_comm[g] = m_run_val[g];
      end
    end
  end

  function automatic logic [15:0] m_ctrl(int g);
    return {7'b0, m_ie[g], 5'b0, m_ovr[g], 1'b0, m_ready[g]};
  endfunction

  function automatic logic [16:0] model_read(logic [15:0] a);
    case (a)
      16'hFFF0: return {1'b1, 12'b0, m_comm[0][3:0]};
      16'hFFF2: return {1'b1, 6'b0, m_comm[1]};
      16'hFFF4: return {1'b1, m_ctrl(0)};
      16'hFFF6: return {1'b1, m_ctrl(1)};
      default:  return {1'b0, 16'hDEAD};
    endcase
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : compare
    logic [16:0] e;
    if (started) begin
      e = model_read(bus.abus);
      check("model_dout", bus.dout, e[15:0]);
      check("model_sel", {15'b0, bus.sel}, {15'b0, e[16]});
      check("model_intr", {15'b0, intr}, {15'b0, m_intr});
    end
  end

  // ---------------- directed helpers ----------------
  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic look(logic [15:0] a, logic [15:0] exp, string nm);
    bus.abus = a;
    #1;
    $display("look %h dout=%h sel=%0d", a, bus.dout, bus.sel);
    check(nm, bus.dout, exp);
  endtask

  task automatic write(logic [15:0] a, logic [15:0] d);
    bus.abus = a;
    bus.din  = d;
    bus.we   = 1'b1;
    step(1);
    bus.we   = 1'b0;
    $display("write %h <= %h", a, d);
  endtask

  task automatic rd_clear(logic [15:0] a);
    bus.abus = a;
    bus.re   = 1'b1;
    step(1);
    bus.re   = 1'b0;
    $display("load %h (side effect)", a);
  endtask

  task automatic check_intr(logic exp, string nm);
    #1;
    $display("intr=%0d", intr);
    check(nm, {15'b0, intr}, {15'b0, exp});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.abus = 16'hFFF8;
    bus.din  = 16'h0000;
    bus.we   = 1'b0;
    bus.re   = 1'b0;
    step(3);
    reset = 1'b0;

    // reset state
    look(16'hFFF0, 16'h000F, "rst_kdata");
    check("rst_sel", {15'b0, bus.sel}, 16'h0001);
    look(16'hFFF2, 16'h0000, "rst_sdata");
    look(16'hFFF4, 16'h0000, "rst_kctrl");
    look(16'hFFF6, 16'h0000, "rst_sctrl");
    look(16'hFFF8, 16'hDEAD, "unmapped_dout");
    check("unmapped_sel", {15'b0, bus.sel}, 16'h0000);

    // key commit latency: visible exactly 7 cycles after the change
    key = 4'hE;
    step(6);
    look(16'hFFF0, 16'h000F, "kdata_before_latency");
    step(1);
    look(16'hFFF0, 16'h000E, "kdata_commit");
    look(16'hFFF4, 16'h0001, "kctrl_ready");

    // 3-cycle glitch is filtered
    key = 4'hC;
    step(3);
    key = 4'hE;
    step(10);
    look(16'hFFF0, 16'h000E, "glitch_kdata");
    look(16'hFFF4, 16'h0001, "glitch_kctrl");

    // second commit without a read -> overrun
    key = 4'hC;
    step(7);
    look(16'hFFF0, 16'h000C, "kdata_second");
    look(16'hFFF4, 16'h0005, "kctrl_overrun");

    // store to a data register is ignored; control write clears
    write(16'hFFF0, 16'h0000);
    look(16'hFFF0, 16'h000C, "we_data_ignored");
    write(16'hFFF4, 16'h0000);
    look(16'hFFF4, 16'h0000, "kctrl_cleared");

    // switches with interrupt enable
    write(16'hFFF6, 16'h0100);
    look(16'hFFF6, INTR_EN ? 16'h0100 : 16'h0000, "sctrl_ie");
    sw = 10'h2A5;
    step(7);
    look(16'hFFF2, 16'h02A5, "sdata_commit");
    look(16'hFFF6, INTR_EN ? 16'h0101 : 16'h0001, "sctrl_ready");
    check_intr(1'b0, "intr_lag");
    step(1);
    check_intr(INTR_EN, "intr_set");
    rd_clear(16'hFFF2);
    look(16'hFFF6, INTR_EN ? 16'h0100 : 16'h0000, "sctrl_read_clear");
    check_intr(INTR_EN, "intr_still_lagging");
    step(1);
    check_intr(1'b0, "intr_cleared");

    // commit coinciding with a clearing read of KDATA
    key = 4'hE;
    step(7);
    look(16'hFFF4, 16'h0001, "kctrl_pre_coincide");
    key = 4'hC;
    step(6);
    bus.abus = 16'hFFF0;
    bus.re   = 1'b1;
    step(1);
    bus.re   = 1'b0;
    look(16'hFFF4, 16'h0001, "coincide_kctrl");
    look(16'hFFF0, 16'h000C, "coincide_kdata");

    // reset in the middle of a debounce
    key = 4'hE;
    sw  = 10'h0F0;
    step(4);
    reset = 1'b1;
    key   = 4'hF;
    sw    = 10'h000;
    step(1);
    reset = 1'b0;
    look(16'hFFF0, 16'h000F, "midrst_kdata");
    look(16'hFFF2, 16'h0000, "midrst_sdata");
    look(16'hFFF4, 16'h0000, "midrst_kctrl");
    look(16'hFFF6, 16'h0000, "midrst_sctrl");
    check_intr(1'b0, "midrst_intr");
    step(12);
    look(16'hFFF0, 16'h000F, "midrst_kdata_late");
    look(16'hFFF2, 16'h0000, "midrst_sdata_late");
    look(16'hFFF4, 16'h0000, "midrst_kctrl_late");

    // switches non-zero across reset release commit after normal latency
    sw    = 10'h155;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(6);
    look(16'hFFF2, 16'h0000, "postrst_sdata_early");
    step(1);
    look(16'hFFF2, 16'h0155, "postrst_sdata");
    look(16'hFFF6, 16'h0001, "postrst_sctrl");
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_sw_dev.md
KEY_SW_DEV -- requirements
Module: key_sw_dev

Interface
REQ-001 Parameter DBITS, 16, data bus width.
REQ-002 Parameter DEBCYC, 50000, cycles an input change must be stable before it commits (range 2..65535).
REQ-003 CLK  input  1  sole clock, rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 ABUS  input  16  data-memory address from the processor M stage.
REQ-006 DIN  input  16  store data.
REQ-007 WE  input  1  store strobe, qualified by CLK.
REQ-008 RE  input  1  load strobe, qualified by CLK; used only for read side effects.
REQ-009 KEY  input  4  raw push-buttons, asynchronous, active-low.
REQ-010 SW  input  10  raw slide switches, asynchronous.
REQ-011 DOUT  output  16  read data, combinational from ABUS.
REQ-012 SEL  output  1  high when ABUS is one of this block's four addresses.
REQ-013 INTR  output  1  registered interrupt request.

Function
REQ-014 Register map: FFF0 KDATA (RO, {12'b0, keys}); FFF2 SDATA (RO, {6'b0, sw}); FFF4 KCTRL; FFF6 SCTRL. Control layout: bit0 READY, bit2 OVERRUN, bit8 IE; all other bits read 0.
REQ-015 For any other ABUS value, SEL = 0 and DOUT = 16'hDEAD.
REQ-016 Each raw input bit passes through a 2-flop synchronizer before any other use.
REQ-017 Keys and switches each use one debounce counter and one candidate register per group; there are no per-bit counters.
REQ-018 Debounce, per group:
  - synchronized value != candidate -> candidate <= synchronized value, counter <= 0;
  - otherwise, if candidate != committed, counter increments; when counter == DEBCYC-1, committed <= candidate;
  - counter holds when candidate == committed.
REQ-019 Latency: from a stable raw change to the committed update is exactly 2 + 1 + DEBCYC cycles. A change shorter than DEBCYC cycles after synchronization never commits.
REQ-020 On a commit cycle: READY <= 1. If READY was already 1 and is not being cleared in the same cycle, OVERRUN <= 1.
REQ-021 RE with ABUS = FFF0 (or FFF2) clears KCTRL.READY (or SCTRL.READY) on that edge.
REQ-022 A commit in the same cycle as a clearing read: READY stays 1 and OVERRUN is unchanged (the new event wins).
REQ-023 WE to a control register:
  - DIN bit0 = 0 clears READY; bit0 = 1 is ignored;
  - DIN bit2 = 0 clears OVERRUN; bit2 = 1 is ignored;
  - bit8 loads IE.
REQ-024 A commit coinciding with a control write: the set wins for READY and OVERRUN; IE takes DIN[8].
REQ-025 WE to FFF0 or FFF2 has no effect. RE has no effect on control registers.
REQ-026 INTR <= (K.READY & K.IE) | (S.READY & S.IE), registered, so it lags the cause by one cycle.
REQ-027 Counters are 16-bit and never wrap; the counter maximum is DEBCYC-1.

Reset
REQ-028 RESET drives, on the next edge:
  - synchronizers, candidate and committed keys to 4'hF; switches to 10'h000;
  - counters, READY, OVERRUN, IE and INTR to 0.
REQ-029 RESET takes priority over every simultaneous event. A debounce in progress is discarded.
REQ-030 Switches not at 0 when RESET is released commit after the normal latency and set READY.

Configuration
REQ-031 Macro KSW_INTR_EN.
  - Defined: IE bits and INTR behave as specified above.
  - Undefined: IE bits read 0 and ignore writes, INTR is constant 0, and no IE or INTR flops exist.

Verification (bench DEBCYC = 4)
REQ-032 Reset, then read FFF0/FFF2/FFF4/FFF6 -> 000F, 0000, 0000, 0000; SEL = 1. Read FFF8 -> SEL = 0, DOUT = DEAD.
REQ-033 KEY 1111 -> 1110 held steady -> KDATA = 000E and KCTRL = 0001 exactly 7 cycles later. A 3-cycle glitch produces no change.
REQ-034 Two key commits with no read between -> KCTRL = 0005. Write 0000 to FFF4 -> KCTRL = 0000.
REQ-035 Write 0100 to FFF6, then SW -> 0x2A5 -> SDATA = 02A5, SCTRL = 0101, INTR = 1 one cycle later. Read FFF2 -> READY = 0, INTR = 0 the cycle after.
REQ-036 Commit coincides with an RE of FFF0 -> KCTRL.READY = 1, OVERRUN = 0.
REQ-037 RESET asserted mid-debounce -> no commit occurs, and all registers are at their reset values.
